// File: rtl/f1_delay_ctrl_if.sv
// Command / response bundle between the F1 light FSM and the delay controller.
// The master (light FSM side) drives the command levels and the driver button.
// The slave (delay controller) returns the step ticks and the timing results.
interface f1_delay_ctrl_if;
  logic        cmd_seq;
  logic        cmd_delay;
  logic        trigger;
  logic        en;
  logic        time_out;
  logic        jump_start;
  logic [15:0] react_time;
  logic        react_valid;

  modport master (
    output cmd_seq, cmd_delay, trigger,
    input  en, time_out, jump_start, react_time, react_valid
  );

  modport slave (
    input  cmd_seq, cmd_delay, trigger,
    output en, time_out, jump_start, react_time, react_valid
  );
endinterface

// File: rtl/f1_delay_ctrl.sv
// f1_delay_ctrl: timing responder for the F1 start-light sequencer.
// Generates light step ticks, runs the pseudo-random lights-out hold delay
// and measures the driver's reaction time in clock cycles.
module f1_delay_ctrl #(
  parameter int unsigned TICK_DIV = 48,
  parameter int unsigned LFSR_W   = 7
) (
  input  logic           clk,
  input  logic           rst_n,
  f1_delay_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEQ   = 2'd1,
    DELAY = 2'd2,
    REACT = 2'd3
  } state_t;

  localparam logic [15:0]       PCNT_LAST = 16'(TICK_DIV - 1);
  localparam logic [LFSR_W-1:0] LFSR_ONE  = LFSR_W'(1);
  localparam logic [15:0]       RCNT_MAX  = 16'hFFFF;

  state_t            state;
  state_t            state_next;
  logic [15:0]       pcnt;
  logic [LFSR_W-1:0] lfsr;
  logic [LFSR_W-1:0] dcnt;
  logic [15:0]       rcnt;
  logic              entry;
  logic              tick;
  logic              expire;
  logic              en_next;
  logic              time_out_next;
  logic              jump_start_next;
  logic              react_valid_next;

  // The prescaler only counts in SEQ/DELAY, so a tick can only occur there.
  assign tick   = ((state == SEQ) || (state == DELAY)) && (pcnt == PCNT_LAST);
  assign expire = tick && (dcnt == LFSR_ONE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic; a cmd_delay drop in DELAY beats a same-cycle expiry.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (bus.cmd_delay)    state_next = DELAY;
        else if (bus.cmd_seq) state_next = SEQ;
      end
      SEQ: begin
        if (bus.cmd_delay)     state_next = DELAY;
        else if (!bus.cmd_seq) state_next = IDLE;
      end
      DELAY: begin
        if (!bus.cmd_delay) state_next = IDLE;
        else if (expire)    state_next = REACT;
      end
      REACT: begin
        if (bus.trigger) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Output decode; each pulse belongs to exactly one state, so they never overlap.
  always_comb begin
    en_next          = 1'b0;
    time_out_next    = 1'b0;
    jump_start_next  = 1'b0;
    react_valid_next = 1'b0;
    case (state)
      SEQ:     en_next          = tick;
      DELAY: begin
        jump_start_next = !bus.cmd_delay;
        time_out_next   = bus.cmd_delay && expire;
      end
      REACT:   react_valid_next = bus.trigger;
      default: ;
    endcase
  end

  // Registered outputs; react_time only changes when a measurement completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.en          <= 1'b0;
      bus.time_out    <= 1'b0;
      bus.jump_start  <= 1'b0;
      bus.react_valid <= 1'b0;
      bus.react_time  <= 16'd0;
    end else begin
      bus.en          <= en_next;
      bus.time_out    <= time_out_next;
      bus.jump_start  <= jump_start_next;
      bus.react_valid <= react_valid_next;
      if (react_valid_next) bus.react_time <= rcnt;
    end
  end

  // Prescaler: restarts on every state change so step timing is relative to entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                            pcnt <= 16'd0;
    else if (state_next != state)                          pcnt <= 16'd0;
    else if (!((state == SEQ) || (state == DELAY)))        pcnt <= 16'd0;
    else if (pcnt == PCNT_LAST)                            pcnt <= 16'd0;
    else                                                   pcnt <= pcnt + 16'd1;
  end

  // Free-running Fibonacci LFSR; seeded non-zero so it never locks up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr <= LFSR_ONE;
    else        lfsr <= {lfsr[LFSR_W-2:0], lfsr[LFSR_W-1] ^ lfsr[LFSR_W-2]};
  end

  // Flags the first cycle spent in a state (used to capture the delay length).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) entry <= 1'b0;
    else        entry <= (state_next != state);
  end

  // Delay counter: captures the LFSR on DELAY entry, counts down once per tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dcnt <= '0;
    end else if (state == DELAY) begin
      if (entry)     dcnt <= lfsr;
      else if (tick) dcnt <= dcnt - LFSR_ONE;
    end
  end

  // Reaction counter: zeroed at lights-out, then saturating count while in REACT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                   rcnt <= 16'd0;
    else if (time_out_next)                       rcnt <= 16'd0;
    else if ((state == REACT) && (rcnt != RCNT_MAX)) rcnt <= rcnt + 16'd1;
  end

endmodule
